// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine timer:
// register indices, CTRL field positions, reset values.
package wb_timer_pkg;

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_PS_LSB = 8;
    localparam int CTRL_PS_MSB = 15;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

    // Replace the bytes of old_v selected by sel with those of new_v.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler for the machine timer: emits one tick every
// PRESCALE+1 enabled cycles; reloadable when CTRL is written.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_en,
    input  logic [7:0] i_prescale,
    input  logic       i_reload,
    input  logic [7:0] i_reload_val,
    output logic       o_tick
);

    logic [7:0] r_cnt;

    assign o_tick = i_en && (r_cnt == 8'd0);

    // Down-count while enabled; reload on terminal count or CTRL write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (i_reload) begin
            r_cnt <= i_reload_val;
        end else if (i_en) begin
            if (r_cnt == 8'd0) r_cnt <= i_prescale;
            else               r_cnt <= r_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone machine timer: 64-bit mtime/mtimecmp, CTRL register,
// prescaled count and registered mtime >= mtimecmp interrupt.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     timer_irq_o
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [7:0]  r_prescale;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_irq;

    logic        w_access;
    logic        w_wr;
    logic [2:0]  w_idx;
    logic        w_tick;
    logic [31:0] w_ctrl_cur;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_rdata;
    logic        w_ctrl_wr;
    logic        w_unused;

    assign w_access  = wb_stb_i && wb_cyc_i && !r_ack;
    assign w_wr      = w_access && wb_we_i;
    assign w_idx     = wb_addr_i[4:2];
    assign w_ctrl_wr = w_wr && (w_idx == REG_CTRL);

    assign w_ctrl_cur = {16'd0, r_prescale, 7'd0, r_en};
    assign w_ctrl_new = byte_merge(w_ctrl_cur, wb_data_i, wb_sel_i);

    assign w_unused = ^{wb_addr_i[WB_ADDR_WIDTH-1:5],
                        wb_addr_i[1:0],
                        w_ctrl_new[31:16],
                        w_ctrl_new[7:1]};

    wb_timer_prescaler u_prescaler (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_en         (r_en),
        .i_prescale   (r_prescale),
        .i_reload     (w_ctrl_wr),
        .i_reload_val (w_ctrl_new[CTRL_PS_MSB:CTRL_PS_LSB]),
        .o_tick       (w_tick)
    );

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            REG_MTIME_LO:    w_rdata = r_mtime[31:0];
            REG_MTIME_HI:    w_rdata = r_mtime[63:32];
            REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            REG_CTRL:        w_rdata = w_ctrl_cur;
            default:         w_rdata = 32'd0;
        endcase
    end

    // Bus handshake: single-cycle ack, read data registered with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= w_access;
            r_rdata <= (w_access && !wb_we_i) ? w_rdata : 32'd0;
        end
    end

    // mtime: a bus write to a half overrides that cycle's increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtime <= 64'd0;
        end else if (w_wr && (w_idx == REG_MTIME_LO)) begin
            r_mtime[31:0] <= byte_merge(r_mtime[31:0], wb_data_i, wb_sel_i);
        end else if (w_wr && (w_idx == REG_MTIME_HI)) begin
            r_mtime[63:32] <= byte_merge(r_mtime[63:32], wb_data_i, wb_sel_i);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp and CTRL are plain byte-masked software registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtimecmp <= MTIMECMP_RST;
            r_en       <= CTRL_RST[CTRL_EN_BIT];
            r_prescale <= CTRL_RST[CTRL_PS_MSB:CTRL_PS_LSB];
        end else if (w_wr) begin
            if (w_idx == REG_MTIMECMP_LO)
                r_mtimecmp[31:0] <=
                    byte_merge(r_mtimecmp[31:0], wb_data_i, wb_sel_i);
            if (w_idx == REG_MTIMECMP_HI)
                r_mtimecmp[63:32] <=
                    byte_merge(r_mtimecmp[63:32], wb_data_i, wb_sel_i);
            if (w_idx == REG_CTRL) begin
                r_en       <= w_ctrl_new[CTRL_EN_BIT];
                r_prescale <= w_ctrl_new[CTRL_PS_MSB:CTRL_PS_LSB];
            end
        end
    end

    // Interrupt level lags the register compare by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_irq <= 1'b0;
        else       r_irq <= (r_mtime >= r_mtimecmp);
    end

    assign wb_ack_o    = r_ack;
    assign wb_data_o   = r_rdata;
    assign timer_irq_o = r_irq;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer; read expectations are queued at
// issue time and a monitor checks them as acks appear.
module tb_wb_timer;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk;
        logic [31:0] d;
        string       nm;
    } exp_t;

    exp_t q[$];

    wb_timer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb_addr_i   (addr),
        .wb_data_i   (wdata),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_stb_i    (stb),
        .wb_cyc_i    (cyc),
        .wb_ack_o    (ack),
        .wb_data_o   (rdata),
        .timer_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack data=%08h", rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (rdata !== e.d) begin
                        errors++;
                        $display("FAIL %s got=%08h exp=%08h",
                                 e.nm, rdata, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", nm, act, exp);
        end
    endtask

    task automatic wb_wr(input logic [2:0] idx, input logic [31:0] d,
                         input logic [3:0] s);
        exp_t e;
        e.chk = 1'b0;
        e.d   = 32'd0;
        e.nm  = "write";
        @(posedge clk);
        #1;
        q.push_back(e);
        addr  = {27'd0, idx, 2'b00};
        wdata = d;
        sel   = s;
        we    = 1'b1;
        stb   = 1'b1;
        cyc   = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_rd(input logic [2:0] idx, input logic [31:0] exp,
                         input string nm);
        exp_t e;
        e.chk = 1'b1;
        e.d   = exp;
        e.nm  = nm;
        @(posedge clk);
        #1;
        q.push_back(e);
        addr = {27'd0, idx, 2'b00};
        we   = 1'b0;
        sel  = 4'hF;
        stb  = 1'b1;
        cyc  = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        cyc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        addr  = 32'd0;
        wdata = 32'd0;
        we    = 1'b0;
        sel   = 4'h0;
        stb   = 1'b0;
        cyc   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Free-running count after reset at one tick per cycle.
        @(posedge clk);
        repeat (9) @(posedge clk);
        wb_rd(3'd0, 32'd11, "mtime_lo_idle");
        wb_rd(3'd1, 32'd0, "mtime_hi_idle");
        wb_rd(3'd4, 32'h0000_0001, "ctrl_rst");
        wb_rd(3'd3, 32'hFFFF_FFFF, "cmp_hi_rst");
        chk("irq_idle", {31'd0, irq}, 32'd0);

        // Prescale 3: one tick every four cycles after the CTRL write.
        wb_wr(3'd4, 32'd0, 4'hF);
        wb_wr(3'd0, 32'd0, 4'hF);
        wb_wr(3'd1, 32'd0, 4'hF);
        wb_wr(3'd4, 32'h0000_0301, 4'hF);
        repeat (15) @(posedge clk);
        wb_rd(3'd0, 32'd4, "presc_rate_a");
        repeat (2) @(posedge clk);
        wb_rd(3'd0, 32'd5, "presc_rate_b");

        // EN = 0 freezes mtime.
        wb_wr(3'd4, 32'd0, 4'hF);
        wb_wr(3'd0, 32'h0000_0055, 4'hF);
        repeat (20) @(posedge clk);
        wb_rd(3'd0, 32'h0000_0055, "frozen_lo");
        wb_rd(3'd1, 32'd0, "frozen_hi");

        // Carry into the high word and compare-triggered interrupt.
        wb_wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wb_wr(3'd2, 32'h0000_0001, 4'hF);
        wb_wr(3'd3, 32'h0000_0001, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_below", {31'd0, irq}, 32'd0);
        wb_wr(3'd4, 32'h0000_0001, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("irq_at_reach", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        wb_rd(3'd1, 32'd1, "mtime_hi_roll");

        // Byte-masked writes.
        wb_wr(3'd2, 32'h1234_5678, 4'hF);
        wb_wr(3'd2, 32'h00AA_0000, 4'b0100);
        wb_rd(3'd2, 32'h12AA_5678, "cmp_lo_bytes");
        wb_wr(3'd4, 32'hFFFF_FF00, 4'hF);
        wb_rd(3'd4, 32'h0000_FF00, "ctrl_fields");
        wb_wr(3'd4, 32'hFFFF_FF01, 4'b0001);
        wb_rd(3'd4, 32'h0000_FF01, "ctrl_sel");

        // Held strobe on an unmapped index: ack every other cycle.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.chk = 1'b1;
            e.d   = 32'd0;
            e.nm  = "unmapped_held";
            q.push_back(e);
        end
        addr = {27'd0, 3'd6, 2'b00};
        we   = 1'b0;
        stb  = 1'b1;
        cyc  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_ack", {31'd0, ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        stb = 1'b1;
        cyc = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no_cyc_ack", {31'd0, ack}, 32'd0);
        end
        stb = 1'b0;
        wb_wr(3'd7, 32'hDEAD_BEEF, 4'hF);
        wb_rd(3'd7, 32'd0, "unmapped_rd");

        // Reset in the middle of a read while irq is high.
        wb_wr(3'd3, 32'd0, 4'hF);
        wb_wr(3'd2, 32'd0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_high", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        addr = {27'd0, 3'd0, 2'b00};
        we   = 1'b0;
        stb  = 1'b1;
        cyc  = 1'b1;
        rst  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        stb = 1'b0;
        cyc = 1'b0;
        wb_rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
        wb_rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        wb_rd(3'd4, 32'h0000_0001, "rst_ctrl");

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_ack pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
